// File: rtl/mtx_pkg.sv
// Shared definitions for the matrix transmit scheduler.
// Holds the FSM state encoding, the byte-phase encoding that tells the
// NEXT state what was just sent, the default frame header byte and the
// acknowledge timeout used while waiting for the transmitter to go busy.
package mtx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_READ,
        ST_LATCH,
        ST_NEXT,
        ST_FINISH
    } state_t;

    // Which byte of the frame currently sits in tx_byte.
    typedef enum logic [1:0] {
        PH_HEADER,
        PH_HIGH,
        PH_LOW,
        PH_CSUM
    } phase_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         ACK_TIMEOUT    = 16;
    localparam int         TMR_W          = $clog2(ACK_TIMEOUT);

    // XOR of the two bytes of a memory word, folded into the running checksum.
    function automatic logic [7:0] fold16(input logic [15:0] w);
        return w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector with a one-flop history.
// Ports:
//   slow_clk - clock
//   rst      - asynchronous active-high reset
//   din      - level input
//   rise     - high for the cycle in which din is high and was low last cycle
// A level that is already high when reset releases is not an edge: the
// detector arms only after it has seen din low at least once.
module rise_det (
    input  logic slow_clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic hist_reg;
    logic armed_reg;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            hist_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            hist_reg <= din;
            if (!din) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign rise = din & ~hist_reg & armed_reg;

endmodule

// File: rtl/matrix_tx_scheduler.sv
// Streams a ROW x COLUMN matrix of 16-bit words out of an external memory
// to an external byte transmitter as one frame:
//   HEADER, {word[15:8], word[7:0]} for every address, XOR checksum.
// Ports:
//   slow_clk, rst      - clock, asynchronous active-high reset
//   start              - level request; a rising edge in IDLE sends one frame
//   rd_en, rd_addr     - one-cycle memory read strobe and linear address
//   rd_data            - memory data, valid the cycle after rd_en
//   tx_start, tx_byte  - one-cycle send request and the byte to send
//   tx_busy            - transmitter busy (asynchronous, synchronised here)
//   busy, done         - frame in progress, one-cycle end-of-frame pulse
module matrix_tx_scheduler
    import mtx_pkg::*;
#(
    parameter int         ROW    = 2,
    parameter int         COLUMN = 2,
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic        slow_clk,
    input  logic        rst,
    input  logic        start,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0]      N_ELEM   = 32'(ROW * COLUMN);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    logic start_rise;

    logic busy_sync1_reg;
    logic busy_sync2_reg;

    state_t           state_reg;
    phase_t           phase_reg;
    logic [31:0]      addr_cnt_reg;   // next element to fetch, 0..N
    logic [7:0]       low_reg;        // low byte waiting behind the high byte
    logic [7:0]       csum_reg;
    logic [TMR_W-1:0] tmr_reg;

    logic        rd_en_reg;
    logic [31:0] rd_addr_reg;
    logic        tx_start_reg;
    logic [7:0]  tx_byte_reg;
    logic        busy_reg;
    logic        done_reg;

    rise_det u_start_det (
        .slow_clk (slow_clk),
        .rst      (rst),
        .din      (start),
        .rise     (start_rise)
    );

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            busy_sync1_reg <= 1'b0;
            busy_sync2_reg <= 1'b0;
        end else begin
            busy_sync1_reg <= tx_busy;
            busy_sync2_reg <= busy_sync1_reg;
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= PH_HEADER;
            addr_cnt_reg <= '0;
            low_reg      <= '0;
            csum_reg     <= '0;
            tmr_reg      <= '0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            tx_start_reg <= 1'b0;
            tx_byte_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            tx_start_reg <= 1'b0;
            rd_en_reg    <= 1'b0;
            done_reg     <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start_rise) begin
                        tx_byte_reg  <= HEADER;
                        phase_reg    <= PH_HEADER;
                        csum_reg     <= '0;
                        addr_cnt_reg <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (!busy_sync2_reg) begin
                        tx_start_reg <= 1'b1;
                        tmr_reg      <= '0;
                        state_reg    <= ST_WAIT_ACK;
                    end
                end

                // A transmitter fast enough to finish before its busy flag
                // survives the synchroniser is covered by the timeout.
                ST_WAIT_ACK: begin
                    if (busy_sync2_reg) begin
                        state_reg <= ST_WAIT_DONE;
                    end else if (tmr_reg == TMR_LAST) begin
                        state_reg <= ST_NEXT;
                    end else begin
                        tmr_reg <= tmr_reg + 1'b1;
                    end
                end

                ST_WAIT_DONE: begin
                    if (!busy_sync2_reg) begin
                        state_reg <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    case (phase_reg)
                        PH_HEADER, PH_LOW: begin
                            if (addr_cnt_reg < N_ELEM) begin
                                // rd_en is high for the whole READ cycle.
                                rd_en_reg   <= 1'b1;
                                rd_addr_reg <= addr_cnt_reg;
                                state_reg   <= ST_READ;
                            end else begin
                                tx_byte_reg <= csum_reg;
                                phase_reg   <= PH_CSUM;
                                state_reg   <= ST_SEND;
                            end
                        end
                        PH_HIGH: begin
                            tx_byte_reg <= low_reg;
                            phase_reg   <= PH_LOW;
                            state_reg   <= ST_SEND;
                        end
                        default: begin
                            state_reg <= ST_FINISH;
                        end
                    endcase
                end

                ST_READ: begin
                    state_reg <= ST_LATCH;
                end

                // Memory answers during this cycle, one after the strobe.
                ST_LATCH: begin
                    low_reg      <= rd_data[7:0];
                    tx_byte_reg  <= rd_data[15:8];
                    csum_reg     <= csum_reg ^ fold16(rd_data);
                    addr_cnt_reg <= addr_cnt_reg + 32'd1;
                    phase_reg    <= PH_HIGH;
                    state_reg    <= ST_SEND;
                end

                ST_FINISH: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en    = rd_en_reg;
    assign rd_addr  = rd_addr_reg;
    assign tx_start = tx_start_reg;
    assign tx_byte  = tx_byte_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_matrix_tx_scheduler.sv
// Self-checking bench: a 2x2 instance and a 1x1 instance, each with a
// memory model and a byte-transmitter model. Expected frames are built from
// the memory contents (header, byte pairs, XOR of the data bytes).
module tb_matrix_tx_scheduler;

    logic slow_clk = 1'b0;
    logic rst;

    logic        start_v    [2];
    logic        rd_en_v    [2];
    logic [31:0] rd_addr_v  [2];
    logic [15:0] rd_data_v  [2];
    logic        tx_start_v [2];
    logic [7:0]  tx_byte_v  [2];
    logic        tx_busy_v  [2];
    logic        busy_v     [2];
    logic        done_v     [2];

    logic [15:0] mem0 [4];
    logic [15:0] mem1 [1];

    int         busy_len  [2];
    logic       hold_busy [2];
    int         busy_cnt  [2] = '{0, 0};
    int         done_cnt  [2] = '{0, 0};
    int         tx_cnt    [2] = '{0, 0};
    logic [7:0] last_byte [2] = '{8'h00, 8'h00};

    logic [7:0] cap_q0 [$];
    logic [7:0] cap_q1 [$];
    logic [7:0] exp_q  [$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 slow_clk = ~slow_clk;

    matrix_tx_scheduler #(.ROW(2), .COLUMN(2), .HEADER(8'hA5)) dut_a (
        .slow_clk (slow_clk),
        .rst      (rst),
        .start    (start_v[0]),
        .rd_en    (rd_en_v[0]),
        .rd_addr  (rd_addr_v[0]),
        .rd_data  (rd_data_v[0]),
        .tx_start (tx_start_v[0]),
        .tx_byte  (tx_byte_v[0]),
        .tx_busy  (tx_busy_v[0]),
        .busy     (busy_v[0]),
        .done     (done_v[0])
    );

    matrix_tx_scheduler #(.ROW(1), .COLUMN(1), .HEADER(8'hA5)) dut_b (
        .slow_clk (slow_clk),
        .rst      (rst),
        .start    (start_v[1]),
        .rd_en    (rd_en_v[1]),
        .rd_addr  (rd_addr_v[1]),
        .rd_data  (rd_data_v[1]),
        .tx_start (tx_start_v[1]),
        .tx_byte  (tx_byte_v[1]),
        .tx_busy  (tx_busy_v[1]),
        .busy     (busy_v[1]),
        .done     (done_v[1])
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            tx_busy_v[i] = hold_busy[i] || (busy_cnt[i] > 0);
        end
    end

    // Memory and transmitter models.
    always @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            busy_cnt[0] <= 0;
            busy_cnt[1] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (tx_start_v[i]) begin
                    busy_cnt[i]  <= busy_len[i];
                    last_byte[i] <= tx_byte_v[i];
                    tx_cnt[i]    <= tx_cnt[i] + 1;
                    if (i == 0) cap_q0.push_back(tx_byte_v[i]);
                    else        cap_q1.push_back(tx_byte_v[i]);
                end else if (busy_cnt[i] > 0) begin
                    busy_cnt[i] <= busy_cnt[i] - 1;
                end
                if (done_v[i]) done_cnt[i] <= done_cnt[i] + 1;
                if (rd_en_v[i]) begin
                    rd_data_v[i] <= (i == 0) ? mem0[rd_addr_v[i][1:0]] : mem1[0];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Continuous protocol checks.
    always @(negedge slow_clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (rd_en_v[i]) begin
                    chk("rd_addr_range",
                        (rd_addr_v[i] < ((i == 0) ? 32'd4 : 32'd1)) ? 32'd1 : 32'd0, 32'd1);
                end
                if (busy_cnt[i] > 0) begin
                    chk("tx_byte_stable", {24'd0, tx_byte_v[i]}, {24'd0, last_byte[i]});
                end
                if (tx_start_v[i]) begin
                    chk("tx_start_while_busy", {31'd0, tx_busy_v[i]}, 32'd0);
                end
            end
        end
    end

    function automatic int cap_size(input int i);
        return (i == 0) ? cap_q0.size() : cap_q1.size();
    endfunction

    function automatic logic [7:0] cap_at(input int i, input int k);
        return (i == 0) ? cap_q0[k] : cap_q1[k];
    endfunction

    task automatic build_exp(input int i);
        logic [7:0]  cs;
        logic [15:0] w;
        int          n;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        n  = (i == 0) ? 4 : 1;
        for (int a = 0; a < n; a++) begin
            w = (i == 0) ? mem0[a] : mem1[0];
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        exp_q.push_back(cs);
    endtask

    task automatic chk_idle_outputs(input int i, input string tag);
        chk({tag, "_rd_en"},    {31'd0, rd_en_v[i]},    32'd0);
        chk({tag, "_rd_addr"},  rd_addr_v[i],           32'd0);
        chk({tag, "_tx_start"}, {31'd0, tx_start_v[i]}, 32'd0);
        chk({tag, "_tx_byte"},  {24'd0, tx_byte_v[i]},  32'd0);
        chk({tag, "_busy"},     {31'd0, busy_v[i]},     32'd0);
        chk({tag, "_done"},     {31'd0, done_v[i]},     32'd0);
    endtask

    // One frame: optional busy hold before start, optional start-to-tx_start
    // latency check, optional second start pulse mid-frame.
    task automatic do_frame(input int i, input string tag, input int toggle_at,
                            input int hold_pre, input bit lat);
        int base;
        int dbase;
        int c;
        build_exp(i);
        base  = cap_size(i);
        dbase = done_cnt[i];
        $display("frame %s: dut %0d, %0d bytes expected, busy_len %0d", tag, i,
                 exp_q.size(), busy_len[i]);
        if (hold_pre > 0) begin
            hold_busy[i] = 1'b1;
            repeat (hold_pre) @(negedge slow_clk);
        end
        start_v[i] = 1'b1;
        @(negedge slow_clk);
        if (lat && hold_pre == 0) begin
            chk({tag, "_lat_busy"},  {31'd0, busy_v[i]},     32'd1);
            chk({tag, "_lat_early"}, {31'd0, tx_start_v[i]}, 32'd0);
            start_v[i] = 1'b0;
            @(negedge slow_clk);
            chk({tag, "_lat_tx_start"}, {31'd0, tx_start_v[i]}, 32'd1);
        end
        start_v[i] = 1'b0;
        if (hold_pre > 0) begin
            repeat (10) @(negedge slow_clk);
            chk({tag, "_held_no_tx"}, 32'(cap_size(i) - base), 32'd0);
            hold_busy[i] = 1'b0;
        end
        if (toggle_at > 0) begin
            repeat (toggle_at) @(negedge slow_clk);
            start_v[i] = 1'b1;
            @(negedge slow_clk);
            start_v[i] = 1'b0;
        end
        c = 0;
        while (done_cnt[i] == dbase && c < 4000) begin
            @(negedge slow_clk);
            c++;
        end
        chk({tag, "_done_seen"}, (c < 4000) ? 32'd1 : 32'd0, 32'd1);
        repeat (30) @(negedge slow_clk);
        chk({tag, "_done_count"}, 32'(done_cnt[i] - dbase), 32'd1);
        chk({tag, "_byte_count"}, 32'(cap_size(i) - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (base + k < cap_size(i)) begin
                chk({tag, "_byte"}, {24'd0, cap_at(i, base + k)}, {24'd0, exp_q[k]});
            end
        end
        chk({tag, "_busy_after"}, {31'd0, busy_v[i]}, 32'd0);
    endtask

    initial begin
        int base;
        int c;
        rst          = 1'b1;
        start_v[0]   = 1'b0;
        start_v[1]   = 1'b0;
        hold_busy[0] = 1'b0;
        hold_busy[1] = 1'b0;
        busy_len[0]  = 3;
        busy_len[1]  = 3;
        rd_data_v[0] = 16'h0000;
        rd_data_v[1] = 16'h0000;
        mem0[0] = 16'h1234;
        mem0[1] = 16'hABCD;
        mem0[2] = 16'h0001;
        mem0[3] = 16'hFF00;
        mem1[0] = 16'h00FF;

        repeat (3) @(negedge slow_clk);
        chk_idle_outputs(0, "reset_a");
        chk_idle_outputs(1, "reset_b");

        // start high across reset release must not launch a frame
        start_v[0] = 1'b1;
        @(negedge slow_clk);
        rst = 1'b0;
        repeat (10) @(negedge slow_clk);
        chk("start_held_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("start_held_no_tx", 32'(tx_cnt[0]), 32'd0);
        start_v[0] = 1'b0;
        repeat (2) @(negedge slow_clk);

        do_frame(0, "frame_basic", 0, 0, 1'b1);
        do_frame(0, "frame_restart_ignored", 20, 0, 1'b0);
        do_frame(0, "frame_busy_held", 0, 20, 1'b0);

        // reset during the fourth byte
        base = tx_cnt[0];
        start_v[0] = 1'b1;
        @(negedge slow_clk);
        start_v[0] = 1'b0;
        c = 0;
        while (tx_cnt[0] < base + 4 && c < 1000) begin
            @(negedge slow_clk);
            c++;
        end
        chk("abort_reach_4th", (c < 1000) ? 32'd1 : 32'd0, 32'd1);
        @(posedge slow_clk);
        #2 rst = 1'b1;
        #1 chk_idle_outputs(0, "abort_async");
        @(negedge slow_clk);
        chk_idle_outputs(0, "abort_held");
        base = tx_cnt[0];
        repeat (3) @(negedge slow_clk);
        rst = 1'b0;
        repeat (25) @(negedge slow_clk);
        chk("abort_no_tx", 32'(tx_cnt[0] - base), 32'd0);
        chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
        $display("abort: reset mid-frame, %0d tx_start after release", tx_cnt[0] - base);
        do_frame(0, "frame_after_abort", 0, 0, 1'b1);

        busy_len[0] = 0;
        do_frame(0, "frame_ack_timeout", 0, 0, 1'b0);
        busy_len[0] = 3;

        do_frame(1, "frame_1x1", 0, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) mem0[k] = 16'($urandom);
            busy_len[0] = int'($urandom_range(1, 6));
            do_frame(0, "frame_rand_2x2", int'($urandom_range(5, 40)), 0, 1'b0);
        end
        for (int r = 0; r < 3; r++) begin
            mem1[0]     = 16'($urandom);
            busy_len[1] = int'($urandom_range(0, 4));
            do_frame(1, "frame_rand_1x1", 0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
